// File: rtl/fact_responder_pkg.sv
// rtl/fact_responder_pkg.sv - register map, FSM encoding and STATUS layout for fact_responder
package fact_responder_pkg;

  localparam logic [1:0] ADDR_N   = 2'd0;
  localparam logic [1:0] ADDR_GO  = 2'd1;
  localparam logic [1:0] ADDR_ST  = 2'd2;
  localparam logic [1:0] ADDR_RES = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int ST_DONE_BIT = 0;
  localparam int ST_ERR_BIT  = 1;
  localparam int ST_BUSY_BIT = 2;

endpackage

// File: rtl/fact_responder_dp.sv
// rtl/fact_responder_dp.sv - factorial datapath: down-counter, running product and result register
module fact_dp
  import fact_responder_pkg::*;
#(
  parameter int unsigned NW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [NW-1:0] i_n,
  input  logic          i_step,
  input  logic          i_latch,
  input  logic          i_clr_res,
  output logic          o_cnt_le1,
  output logic [31:0]   o_result
);

  logic [NW-1:0] r_cnt;
  logic [31:0]   r_prod;
  logic [31:0]   r_result;
  logic [31:0]   w_mult;

  // Product is kept modulo 2^32; the FSM never lets n exceed the overflow-free limit.
  assign w_mult    = r_prod * 32'(r_cnt);
  assign o_cnt_le1 = (r_cnt <= NW'(1));
  assign o_result  = r_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      if (i_load) begin
        r_cnt  <= i_n;
        r_prod <= 32'd1;
      end else if (i_step) begin
        r_prod <= w_mult;
        r_cnt  <= r_cnt - NW'(1);
      end
      if (i_clr_res) begin
        r_result <= '0;
      end else if (i_latch) begin
        r_result <= r_prod;
      end
    end
  end

endmodule

// File: rtl/fact_responder.sv
// rtl/fact_responder.sv - memory-mapped iterative factorial accelerator on the data-memory bus
module fact_responder
  import fact_responder_pkg::*;
#(
  parameter int unsigned NW   = 4,
  parameter int unsigned MAXN = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  state_t        r_state;
  logic [NW-1:0] r_n;
  logic          r_done;
  logic          r_err;
  logic          r_busy;

  logic        w_wr;
  logic        w_go;
  logic        w_can_go;
  logic        w_n_err;
  logic        w_load;
  logic        w_clr;
  logic        w_step;
  logic        w_latch;
  logic        w_cnt_le1;
  logic [31:0] w_result;
  logic        w_unused;

  assign w_wr     = cs & we;
  assign w_go     = w_wr & (a == ADDR_GO) & wd[0];
  assign w_can_go = (r_state != S_BUSY);
  assign w_n_err  = (32'(r_n) > MAXN);
  assign w_load   = w_go & w_can_go & ~w_n_err;
  assign w_clr    = w_go & w_can_go & w_n_err;
  assign w_step   = (r_state == S_BUSY) & ~w_cnt_le1;
  assign w_latch  = (r_state == S_BUSY) & w_cnt_le1;
  assign w_unused = ^wd[31:NW];

  fact_dp #(.NW(NW)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_n       (r_n),
    .i_step    (w_step),
    .i_latch   (w_latch),
    .i_clr_res (w_clr),
    .o_cnt_le1 (w_cnt_le1),
    .o_result  (w_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_wr && (a == ADDR_N)) begin
        r_n <= wd[NW-1:0];
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_clr) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_load) begin
            r_state <= S_BUSY;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_latch) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read so the single-cycle core sees data in the same cycle.
  always_comb begin
    rd = '0;
    if (cs) begin
      case (a)
        ADDR_N:   rd[NW-1:0] = r_n;
        ADDR_ST: begin
          rd[ST_DONE_BIT] = r_done;
          rd[ST_ERR_BIT]  = r_err;
          rd[ST_BUSY_BIT] = r_busy;
        end
        ADDR_RES: rd = w_result;
        default:  rd = '0;
      endcase
    end
  end

endmodule
